adc_reg_slave: RTL and testbench

ADC_REG_SLAVE -- requirements
Module: adc_reg_slave

---
 rtl/adc_pkg.sv | 31 +++
 rtl/adc_reg_bank.sv | 28 ++
 rtl/adc_reg_slave.sv | 169 ++++++++++++++++
 tb/tb_adc_reg_slave.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants for the ADC serial register slave: frame field widths,
// FSM state encoding and register address map.
package adc_pkg;
    localparam int RW_W       = 1;
    localparam int ADDR_W     = 4;
    localparam int DUMMY_W    = 2;
    localparam int FRM_DATA_W = 9;
    localparam int FRAME_W    = RW_W + ADDR_W + DUMMY_W + FRM_DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        RW,
        ADDR,
        DUMMY,
        DATA,
        WAIT_HIGH
    } state_e;

    localparam logic [ADDR_W-1:0] CONFIG1  = 4'd0;
    localparam logic [ADDR_W-1:0] CONFIG2  = 4'd1;
    localparam logic [ADDR_W-1:0] CONFIG3  = 4'd2;
    localparam logic [ADDR_W-1:0] CONFIG4  = 4'd3;
    localparam logic [ADDR_W-1:0] GAINA1   = 4'd4;
    localparam logic [ADDR_W-1:0] GAINA2   = 4'd5;
    localparam logic [ADDR_W-1:0] GAINB1   = 4'd6;
    localparam logic [ADDR_W-1:0] GAINB2   = 4'd7;
    localparam logic [ADDR_W-1:0] OFFSETA1 = 4'd8;
    localparam logic [ADDR_W-1:0] OFFSETA2 = 4'd9;
    localparam logic [ADDR_W-1:0] OFFSETB1 = 4'd10;
    localparam logic [ADDR_W-1:0] OFFSETB2 = 4'd11;
endpackage

// File: rtl/adc_reg_bank.sv
// Register bank: one write port, all registers exposed on a flat read bus.
module adc_reg_bank
    import adc_pkg::*;
#(
    parameter int NUM_REGS = 12,
    parameter int DATA_W   = FRM_DATA_W,
    parameter int RST_VAL  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                regs_q[g] <= DATA_W'(RST_VAL);
            else if (we && addr == ADDR_W'(g))
                regs_q[g] <= wdata;
        end
    end

    assign regs_flat = regs_q;
endmodule

// File: rtl/adc_reg_slave.sv
// Serial register slave: 16-bit MSB-first frames (R/W, addr, 2 dummy, data)
// sampled on rising adc_clk; read data shifted out during the data phase.
module adc_reg_slave
    import adc_pkg::*;
#(
    parameter int NUM_REGS = 12,
    parameter int DATA_W   = FRM_DATA_W,
    parameter int RST_VAL  = 0
) (
    input  logic                       adc_clk,
    input  logic                       reset,
    input  logic                       ad_sload,
    input  logic                       ad_sdata,
    output logic                       ad_sdata_out,
    output logic                       ad_sdata_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);
    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, waddr_q, waddr_d;
    logic [DATA_W-2:0]   data_q, data_d, snap_q, snap_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                out_q, out_d, oe_q, oe_d, strb_q, strb_d, err_q, err_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic                rst_seen_q, rst_seen_d;
    logic                we, addr_ok;
    logic [DATA_W-1:0]   wdata, rd_data;

    adc_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_bank (
        .clk       (adc_clk),
        .rst       (reset),
        .we        (we),
        .addr      (addr_q),
        .wdata     (wdata),
        .regs_flat (regs_flat)
    );

    assign addr_ok = int'(addr_q) < NUM_REGS;
    assign wdata   = {data_q, ad_sdata};

    // Out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == ADDR_W'(i)) rd_data = regs_flat[i*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        oe_d       = oe_q;
        waddr_d    = waddr_q;
        fcnt_d     = fcnt_q;
        strb_d     = 1'b0;
        err_d      = 1'b0;
        we         = 1'b0;
        rst_seen_d = 1'b0;
        if (ad_sload && (state_q == ADDR || state_q == DUMMY || state_q == DATA)) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A frame cut by reset must not be resumed mid-stream.
                    if (rst_seen_q) begin
                        if (!ad_sload) state_d = WAIT_HIGH;
                    end else if (!ad_sload) begin
                        rw_d    = ad_sdata;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_d = {addr_q[ADDR_W-2:0], ad_sdata};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(ADDR_W-1)) begin
                        cnt_d   = '0;
                        state_d = DUMMY;
                    end
                end
                DUMMY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(DUMMY_W-1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                        if (!rw_q) begin
                            oe_d   = 1'b1;
                            out_d  = rd_data[DATA_W-1];
                            snap_d = rd_data[DATA_W-2:0];
                        end
                    end
                end
                DATA: begin
                    data_d = {data_q[DATA_W-3:0], ad_sdata};
                    cnt_d  = cnt_q + 4'd1;
                    out_d  = oe_q & snap_q[DATA_W-2];
                    snap_d = snap_q << 1;
                    if (cnt_q == 4'(DATA_W-1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_HIGH;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                        fcnt_d  = fcnt_q + 16'd1;
                        if (!addr_ok) begin
                            err_d = 1'b1;
                        end else if (rw_q) begin
                            we      = 1'b1;
                            strb_d  = 1'b1;
                            waddr_d = addr_q;
                        end
                    end
                end
                WAIT_HIGH: if (ad_sload) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            oe_q       <= 1'b0;
            strb_q     <= 1'b0;
            waddr_q    <= '0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
            rst_seen_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            strb_q     <= strb_d;
            waddr_q    <= waddr_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
            rst_seen_q <= rst_seen_d;
        end
    end

    assign ad_sdata_out = out_q;
    assign ad_sdata_oe  = oe_q;
    assign wr_strobe    = strb_q;
    assign wr_addr      = waddr_q;
    assign frame_err    = err_q;
    assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_adc_reg_slave.sv
// Scoreboard bench for adc_reg_slave: directed plus random frames against a
// frame-level model; a monitor checks every strobe, error pulse and read bit.
module tb_adc_reg_slave;
    localparam int NR = 12;
    localparam int DW = 9;

    logic             clk = 1'b0, rst = 1'b1, sload = 1'b1, sdata = 1'b0;
    logic             sdo, sdo_oe, wr_strobe, frame_err;
    logic [NR*DW-1:0] regs_flat;
    logic [3:0]       wr_addr;
    logic [15:0]      frame_cnt;

    adc_reg_slave dut (
        .adc_clk      (clk),
        .reset        (rst),
        .ad_sload     (sload),
        .ad_sdata     (sdata),
        .ad_sdata_out (sdo),
        .ad_sdata_oe  (sdo_oe),
        .regs_flat    (regs_flat),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int fcnt;} wr_t;
    wr_t q_wr[$];
    int  q_err[$];
    int  q_rd[$];
    int  model[16];
    int  m_fcnt;
    int  n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected events are derived from the frame contents, then the frame is driven.
    task automatic send_frame(input bit rw, input int addr, input int data,
                              input int abort_k, input int gap);
        logic [15:0] f;
        logic [8:0]  rdv;
        int nbits, nrd;
        f     = {rw, addr[3:0], 2'($urandom), data[8:0]};
        nbits = (abort_k < 0) ? 16 : abort_k;
        rdv   = (addr < NR) ? model[addr][8:0] : 9'd0;
        nrd   = (nbits > 6) ? ((nbits - 6 > 9) ? 9 : nbits - 6) : 0;
        if (!rw)
            for (int j = 0; j < nrd; j++) q_rd.push_back(int'(rdv[8-j]));
        if (abort_k >= 0) begin
            q_err.push_back(m_fcnt);
        end else begin
            m_fcnt = (m_fcnt + 1) & 32'hFFFF;
            if (addr >= NR) q_err.push_back(m_fcnt);
            else if (rw) begin
                model[addr] = data;
                q_wr.push_back('{addr, data, m_fcnt});
            end
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sload = 1'b0;
            sdata = f[15-i];
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            sload = 1'b1;
            sdata = 1'($urandom);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_strobe) begin
                    chk("wr_strobe expected", 32'(q_wr.size() > 0), 1);
                    if (q_wr.size() > 0) begin
                        wr_t e;
                        e = q_wr.pop_front();
                        chk("wr_addr", 32'(wr_addr), e.addr);
                        chk("wr_data", 32'(regs_flat[e.addr*DW +: DW]), e.data);
                        chk("wr_fcnt", 32'(frame_cnt), e.fcnt);
                    end
                end
                if (frame_err) begin
                    chk("frame_err expected", 32'(q_err.size() > 0), 1);
                    if (q_err.size() > 0) chk("err_fcnt", 32'(frame_cnt), q_err.pop_front());
                end
                if (sdo_oe) begin
                    chk("rd bit expected", 32'(q_rd.size() > 0), 1);
                    if (q_rd.size() > 0) chk("rd bit", 32'(sdo), q_rd.pop_front());
                end else begin
                    chk("sdata_out idle", 32'(sdo), 0);
                end
            end
        end
    end

    task automatic check_all_regs(input string nm);
        for (int a = 0; a < NR; a++)
            chk($sformatf("%s reg%0d", nm, a), 32'(regs_flat[a*DW +: DW]), model[a]);
    endtask

    task automatic check_reset_outputs();
        chk("rst oe", 32'(sdo_oe), 0);
        chk("rst out", 32'(sdo), 0);
        chk("rst strobe", 32'(wr_strobe), 0);
        chk("rst wr_addr", 32'(wr_addr), 0);
        chk("rst err", 32'(frame_err), 0);
        chk("rst fcnt", 32'(frame_cnt), 0);
        check_all_regs("rst");
    endtask

    initial begin
        logic [15:0] f;
        int rw, addr, k;
        foreach (model[i]) model[i] = 0;
        m_fcnt = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_frame(1, 2, 'h1A5, -1, 3);
        chk("req032 reg2", 32'(regs_flat[26:18]), 'h1A5);
        chk("req032 fcnt", 32'(frame_cnt), 1);

        for (int a = 0; a < NR; a++) send_frame(1, a, a * 'h21, -1, 3);
        check_all_regs("req033");
        chk("req033 fcnt", 32'(frame_cnt), 13);

        send_frame(1, 5, 'h0F3, -1, 2);
        send_frame(0, 5, 0, -1, 2);
        send_frame(1, 13, 'h1FF, -1, 2);
        check_all_regs("req035");
        send_frame(1, 3, 'h12C, 11, 2);
        chk("req036 reg3", 32'(regs_flat[3*DW +: DW]), 3 * 'h21);
        send_frame(1, 3, 'h12C, -1, 1);
        send_frame(0, 14, 0, -1, 1);

        for (int n = 0; n < 200; n++) begin
            rw   = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 15));
            k    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : -1;
            send_frame(rw[0], addr, int'($urandom_range(0, 511)), k, int'($urandom_range(1, 3)));
        end
        check_all_regs("random");
        chk("random fcnt", 32'(frame_cnt), m_fcnt);

        send_frame(1, 0, 'h055, -1, 3);
        f = {1'b1, 4'd0, 2'b00, 9'h1AA};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sload = 1'b0;
            sdata = f[15-i];
        end
        @(negedge clk);
        rst = 1'b1;
        foreach (model[i]) model[i] = 0;
        m_fcnt = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sdata = 1'($urandom);
        end
        #1;
        chk("post-reset fcnt", 32'(frame_cnt), 0);
        check_all_regs("post-reset");
        @(negedge clk);
        sload = 1'b1;
        @(negedge clk);
        send_frame(1, 0, 'h0AB, -1, 2);
        send_frame(0, 0, 0, -1, 2);

        repeat (4) @(negedge clk);
        chk("wr queue drained", 32'(q_wr.size()), 0);
        chk("err queue drained", 32'(q_err.size()), 0);
        chk("rd queue drained", 32'(q_rd.size()), 0);
        chk("final fcnt", 32'(frame_cnt), m_fcnt);
        check_all_regs("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
